// File: rtl/apb_resp_stub_pkg.sv
// ============================================================================
// Module : apb_resp_stub_pkg
// Brief  : Shared types, widths and address helper for the APB response stub.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apb_resp_stub_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int unsigned c_WAIT_CNT_WIDTH = 4;
    localparam int unsigned c_XFER_CNT_WIDTH = 16;

    // Full-width word index so out-of-range addresses never alias into the file.
    function automatic logic [63:0] word_index(input logic [63:0] paddr,
                                               input int unsigned data_width);
        return paddr >> $clog2(data_width / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_resp_stub_chan.sv
// ============================================================================
// Module : apb_resp_stub_chan
// Brief  : One APB completer: FSM, wait counter, register file, decode and
//          saturating transfer counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_resp_stub_chan
    import apb_resp_stub_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH    = 32,
    parameter int unsigned          DATA_WIDTH    = 32,
    parameter int unsigned          NR_REGS       = 8,
    parameter int unsigned          WAIT_CYCLES   = 0,
    parameter logic [DATA_WIDTH-1:0] REG_RESET_VAL = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic                        pwrite_i,
    input  logic [ADDR_WIDTH-1:0]       paddr_i,
    input  logic [DATA_WIDTH-1:0]       pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]     pstrb_i,
    output logic [DATA_WIDTH-1:0]       prdata_o,
    output logic                        pready_o,
    output logic                        pslverr_o,
    output logic [c_XFER_CNT_WIDTH-1:0] xfer_cnt_o
);

    localparam int unsigned c_IDX_W = $clog2(NR_REGS);
    localparam logic [c_WAIT_CNT_WIDTH-1:0] c_WAIT = c_WAIT_CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [c_XFER_CNT_WIDTH-1:0] c_XFER_MAX = '1;

    state_e                        r_state;
    logic [c_WAIT_CNT_WIDTH-1:0]   r_wait_cnt;
    logic [c_XFER_CNT_WIDTH-1:0]   r_xfer_cnt;
    logic [DATA_WIDTH-1:0]         r_regs [NR_REGS];

    logic [63:0]                   w_idx_full;
    logic [c_IDX_W-1:0]            w_idx;
    logic                          w_oor;
    logic                          w_ready;

    assign w_idx_full = word_index(64'(paddr_i), DATA_WIDTH);
    assign w_idx      = w_idx_full[c_IDX_W-1:0];
    assign w_oor      = (w_idx_full >= 64'(NR_REGS));
    assign w_ready    = (r_state == ACCESS) && (r_wait_cnt == c_WAIT);

    assign pready_o   = w_ready;
    assign pslverr_o  = w_ready && w_oor;
    assign prdata_o   = (w_ready && !w_oor) ? r_regs[w_idx] : '0;
    assign xfer_cnt_o = r_xfer_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_xfer_cnt <= '0;
            for (int i = 0; i < int'(NR_REGS); i++) begin
                r_regs[i] <= REG_RESET_VAL;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Enable without a prior setup phase is ignored entirely.
                    if (psel_i && !penable_i) begin
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (!psel_i) begin
                        r_state <= IDLE;
                    end else if (penable_i) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else if (w_ready) begin
                        r_state    <= penable_i ? IDLE : SETUP;
                        r_wait_cnt <= '0;
                        if (r_xfer_cnt != c_XFER_MAX) begin
                            r_xfer_cnt <= r_xfer_cnt + 1'b1;
                        end
                        if (pwrite_i && !w_oor) begin
                            for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
                                if (pstrb_i[b]) begin
                                    r_regs[w_idx][8*b +: 8] <= pwdata_i[8*b +: 8];
                                end
                            end
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_resp_stub.sv
// ============================================================================
// Module : apb_resp_stub
// Brief  : Multi-channel APB completer stub; independent channels share one
//          request bus and respond on their own output slices.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_resp_stub
    import apb_resp_stub_pkg::*;
#(
    parameter int unsigned           NR_CHANNELS   = 1,
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           NR_REGS       = 8,
    parameter int unsigned           WAIT_CYCLES   = 0,
    parameter logic [DATA_WIDTH-1:0] REG_RESET_VAL = '0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NR_CHANNELS-1:0]                   psel_i,
    input  logic                                     penable_i,
    input  logic                                     pwrite_i,
    input  logic [ADDR_WIDTH-1:0]                    paddr_i,
    input  logic [DATA_WIDTH-1:0]                    pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]                  pstrb_i,
    output logic [NR_CHANNELS*DATA_WIDTH-1:0]        prdata_o,
    output logic [NR_CHANNELS-1:0]                   pready_o,
    output logic [NR_CHANNELS-1:0]                   pslverr_o,
    output logic [NR_CHANNELS*c_XFER_CNT_WIDTH-1:0]  xfer_cnt_o
);

    for (genvar c = 0; c < int'(NR_CHANNELS); c++) begin : g_chan
        apb_resp_stub_chan #(
            .ADDR_WIDTH    (ADDR_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .NR_REGS       (NR_REGS),
            .WAIT_CYCLES   (WAIT_CYCLES),
            .REG_RESET_VAL (REG_RESET_VAL)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .psel_i     (psel_i[c]),
            .penable_i  (penable_i),
            .pwrite_i   (pwrite_i),
            .paddr_i    (paddr_i),
            .pwdata_i   (pwdata_i),
            .pstrb_i    (pstrb_i),
            .prdata_o   (prdata_o[c*DATA_WIDTH +: DATA_WIDTH]),
            .pready_o   (pready_o[c]),
            .pslverr_o  (pslverr_o[c]),
            .xfer_cnt_o (xfer_cnt_o[c*c_XFER_CNT_WIDTH +: c_XFER_CNT_WIDTH])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_resp_stub.sv
// ============================================================================
// Module : tb_apb_resp_stub
// Brief  : Directed scoreboard bench for apb_resp_stub across four configs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_resp_stub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;

    logic [0:0]  psel_w0, psel_w3, psel_w5;
    logic [1:0]  psel_w2;
    logic [31:0] rd_w0, rd_w3, rd_w5;
    logic [63:0] rd_w2;
    logic [0:0]  rdy_w0, rdy_w3, rdy_w5, err_w0, err_w3, err_w5;
    logic [1:0]  rdy_w2, err_w2;
    logic [15:0] cnt_w0, cnt_w3, cnt_w5;
    logic [31:0] cnt_w2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    apb_resp_stub #(.NR_CHANNELS(1), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel_w0), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(rd_w0), .pready_o(rdy_w0), .pslverr_o(err_w0), .xfer_cnt_o(cnt_w0));

    apb_resp_stub #(.NR_CHANNELS(1), .WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel_w3), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(rd_w3), .pready_o(rdy_w3), .pslverr_o(err_w3), .xfer_cnt_o(cnt_w3));

    apb_resp_stub #(.NR_CHANNELS(2), .WAIT_CYCLES(2)) u_w2 (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel_w2), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(rd_w2), .pready_o(rdy_w2), .pslverr_o(err_w2), .xfer_cnt_o(cnt_w2));

    apb_resp_stub #(.NR_CHANNELS(1), .WAIT_CYCLES(5), .REG_RESET_VAL(32'h0BAD_F00D)) u_w5 (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel_w5), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(rd_w5), .pready_o(rdy_w5), .pslverr_o(err_w5), .xfer_cnt_o(cnt_w5));

    function automatic logic get_rdy(input int d, input int ch);
        case (d)
            0:       return rdy_w0[0];
            1:       return rdy_w3[0];
            2:       return rdy_w2[ch];
            default: return rdy_w5[0];
        endcase
    endfunction

    function automatic logic get_err(input int d, input int ch);
        case (d)
            0:       return err_w0[0];
            1:       return err_w3[0];
            2:       return err_w2[ch];
            default: return err_w5[0];
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int d, input int ch);
        case (d)
            0:       return rd_w0;
            1:       return rd_w3;
            2:       return rd_w2[ch*32 +: 32];
            default: return rd_w5;
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(input int d, input int ch);
        case (d)
            0:       return cnt_w0;
            1:       return cnt_w3;
            2:       return cnt_w2[ch*16 +: 16];
            default: return cnt_w5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_psel(input int d, input int ch, input logic v);
        psel_w0 = '0; psel_w3 = '0; psel_w2 = '0; psel_w5 = '0;
        case (d)
            0:       psel_w0[0]  = v;
            1:       psel_w3[0]  = v;
            2:       psel_w2[ch] = v;
            default: psel_w5[0]  = v;
        endcase
    endtask

    task automatic start(input int d, input int ch, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        @(posedge clk); #1;
        set_psel(d, ch, 1'b1);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
    endtask

    task automatic release_bus();
        set_psel(0, 0, 1'b0);
        penable = 1'b0;
    endtask

    // Full transfer; latency counts clock edges from psel assertion to the ready cycle.
    task automatic xfer(input string tag, input int d, input int ch, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic chk_data, input logic exp_err,
                        input int exp_lat);
        int   lat;
        logic got;
        exp_t e;
        sb.push_back('{rdata: exp_rd, chk_data: chk_data, err: exp_err, lat: exp_lat});
        start(d, ch, wr, addr, data, strb);
        lat = 1;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (get_rdy(d, ch)) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        e = sb.pop_front();
        check({tag, "_ready"}, 64'(got), 64'(1));
        if (got) begin
            check({tag, "_lat"}, 64'(lat), 64'(e.lat));
            check({tag, "_err"}, 64'(get_err(d, ch)), 64'(e.err));
            if (e.chk_data) check({tag, "_rdata"}, 64'(get_rd(d, ch)), 64'(e.rdata));
        end
        @(posedge clk); #1;
        release_bus();
    endtask

    initial begin
        rst_n = 1'b0;
        release_bus();
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_w0", 64'(rdy_w0), 64'(0));
        check("rst_rdata_w0", 64'(rd_w0), 64'(0));
        check("rst_cnt_w2",   64'(cnt_w2), 64'(0));
        check("rst_err_w3",   64'(err_w3), 64'(0));
        rst_n = 1'b1;

        // Zero wait states: basic write/read, partial strobes, unaligned and last index
        xfer("w0_wr4",  0, 0, 1'b1, 32'h4,  32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, 2);
        xfer("w0_rd4",  0, 0, 1'b0, 32'h4,  32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
        @(negedge clk);
        check("w0_cnt2", 64'(cnt_w0), 64'(2));
        xfer("w0_wr0",  0, 0, 1'b1, 32'h0,  32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b0, 2);
        xfer("w0_wrp",  0, 0, 1'b1, 32'h0,  32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b0, 2);
        xfer("w0_rdp",  0, 0, 1'b0, 32'h0,  32'h0, 4'h0, 32'h11BB_33DD, 1'b1, 1'b0, 2);
        xfer("w0_rdu",  0, 0, 1'b0, 32'h6,  32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
        xfer("w0_wr7",  0, 0, 1'b1, 32'h1C, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, 2);
        xfer("w0_rd7",  0, 0, 1'b0, 32'h1F, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, 2);
        xfer("w0_oorr", 0, 0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 2);
        xfer("w0_oorw", 0, 0, 1'b1, 32'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1, 2);
        xfer("w0_rd7b", 0, 0, 1'b0, 32'h1C, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, 2);
        xfer("w0_rd0b", 0, 0, 1'b0, 32'h0,  32'h0, 4'h0, 32'h11BB_33DD, 1'b1, 1'b0, 2);
        @(negedge clk);
        check("w0_cnt12", 64'(cnt_w0), 64'(12));

        // Three wait states
        xfer("w3_rd0",  1, 0, 1'b0, 32'h0,  32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 5);
        xfer("w3_oor",  1, 0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 5);
        @(negedge clk);
        check("w3_cnt2", 64'(cnt_w3), 64'(2));

        // Two channels: ch1 write, ch0 aborted mid-wait
        xfer("w2c1_wr8", 2, 1, 1'b1, 32'h8, 32'h5, 4'hF, 32'h0, 1'b0, 1'b0, 4);
        start(2, 0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        repeat (2) begin
            @(negedge clk);
            check("w2c0_abort_rdy", 64'(rdy_w2[0]), 64'(0));
            @(posedge clk); #1;
        end
        release_bus();
        @(negedge clk);
        check("w2c0_abort_cnt", 64'(cnt_w2[15:0]), 64'(0));
        check("w2c1_cnt1", 64'(cnt_w2[31:16]), 64'(1));
        xfer("w2c1_rd8", 2, 1, 1'b1 ^ 1'b1, 32'h8, 32'h0, 4'h0, 32'h5, 1'b1, 1'b0, 4);
        xfer("w2c0_rd8", 2, 0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4);
        @(negedge clk);
        check("w2c1_cnt2", 64'(cnt_w2[31:16]), 64'(2));
        check("w2c0_cnt1", 64'(cnt_w2[15:0]), 64'(1));

        // Reset mid-access with a write pending
        xfer("w5_wr0", 3, 0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, 7);
        xfer("w5_rd0", 3, 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 1'b0, 7);
        start(3, 0, 1'b1, 32'h4, 32'hCAFE_0001, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("w5_rst_rdy",  64'(rdy_w5), 64'(0));
        check("w5_rst_rd",   64'(rd_w5),  64'(0));
        check("w5_rst_cnt",  64'(cnt_w5), 64'(0));
        check("w0_rst_cnt",  64'(cnt_w0), 64'(0));
        release_bus();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        xfer("w5_rd0r", 3, 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 7);
        xfer("w5_rd4r", 3, 0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_resp_stub.md
Name: apb_resp_stub

Overview:
- Parametrised, multi-channel APB completer stub.
- Used by SoC analysis and lint wrappers in place of constant tie-offs on peripheral APB response ports, e.g. the UART prdata/pready/pslverr inputs of ara_soc.
- Each channel has a small register file, configurable wait states and out-of-range error response, so wrapped designs see real handshake activity instead of a stuck-idle bus.

Parameters:
- NrChannels, 1, number of independent APB completers sharing one request bus.
- AddrWidth, 32, APB address width.
- DataWidth, 32, APB data width; legal values 32 and 64.
- NrRegs, 8, words per channel register file; power of two, at least 2.
- WaitCycles, 0, access-phase wait states before pready; range 0..15.
- RegResetVal, 0, reset value of every register word.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  NrChannels  per-channel select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write.
- paddr_i  in  AddrWidth  byte address.
- pwdata_i  in  DataWidth  write data.
- pstrb_i  in  DataWidth/8  byte strobes.
- prdata_o  out  NrChannels*DataWidth  per-channel read data, channel c at slice c.
- pready_o  out  NrChannels  per-channel ready.
- pslverr_o  out  NrChannels  per-channel error.
- xfer_cnt_o  out  NrChannels*16  per-channel completed-transfer count, saturating.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset state: all registers = RegResetVal, wait counters = 0, xfer_cnt_o = 0. pready_o, pslverr_o and prdata_o are 0 whenever the channel is not in the access phase.
- Per-channel FSM, states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP when psel_i[c] & !penable_i.
  - SETUP -> ACCESS when psel_i[c] & penable_i.
  - ACCESS -> IDLE on completion (pready_o[c] high).
  - Any state -> IDLE when psel_i[c] is low.
  - IDLE with psel_i[c] & penable_i (no setup phase) is a protocol violation: stay IDLE, no response, no write.
  - Completion is followed by SETUP if psel_i[c] & !penable_i (back-to-back transfer).
- Wait counter:
  - 4-bit, counts cycles spent in ACCESS.
  - pready_o[c] = (state == ACCESS) & (cnt == WaitCycles), combinational from registered state and counter.
  - WaitCycles = 0 gives ready in the first access cycle, so a transfer takes 2 cycles total. Latency is 2 + WaitCycles cycles from psel assertion.
  - Counter clears on completion and on leaving ACCESS.
- Address decode:
  - Word index = paddr_i >> log2(DataWidth/8).
  - Out of range if index >= NrRegs; the upper address bits are not aliased.
  - Unaligned low address bits are ignored.
- Completion cycle:
  - Write: strobed byte lanes of the indexed register update at the clock edge; other lanes hold.
  - Read: prdata_o slice = indexed register, driven only while pready is high.
  - Out of range: pslverr_o[c] = 1 with pready, write dropped, prdata slice = 0.
  - pslverr_o[c] is 0 outside out-of-range completions.
- xfer_cnt_o[c] increments by 1 on every completion, error completions included, and saturates at 16'hFFFF.
- Simultaneous selects: channels are fully independent. More than one psel high at once is legal for the stub; each channel responds on its own slice.
- Abort cases:
  - psel dropped mid-wait: transfer aborted, no write, no count, counter cleared.
  - Reset mid-transfer: immediate return to IDLE, outputs 0, registers restored.
- Inputs are sampled only in SETUP/ACCESS. pwdata/paddr changes between SETUP and ACCESS are not checked; values at completion are used.

Decomposition:
- Package apb_resp_stub_pkg holds:
  - state enum (IDLE/SETUP/ACCESS);
  - WaitCntWidth = 4, XferCntWidth = 16;
  - function word_index(paddr, DataWidth).
- Sub-module apb_resp_stub_chan: one channel (FSM, counter, register file, decode, transfer counter). The top generates NrChannels instances and packs the output slices.

Test Plan:
- WaitCycles=0, ch0: write 32'hDEAD_BEEF to 0x4 with pstrb=4'hF, then read 0x4 -> pready high in access cycle 1 both times, prdata=32'hDEADBEEF, pslverr=0, xfer_cnt=2.
- WaitCycles=3, ch0: read 0x0 after reset (RegResetVal=0) -> pready low for 3 access cycles and high on the 4th, prdata=0.
- Partial strobe: reg0=32'h1122_3344, write 32'hAABB_CCDD with pstrb=4'b0101 -> read returns 32'h11BB_33DD.
- NrRegs=8, read 0x20 and write 0x3C -> pslverr=1 with pready on both, prdata=0, register file unchanged, xfer_cnt incremented to 2.
- NrChannels=2: ch1 writes 0x8=5 while ch0 idle; psel dropped during ch0 wait (WaitCycles=2) -> ch0 no write and xfer_cnt0=0; ch1 read of 0x8 returns 5, xfer_cnt1=2.
- Reset asserted in ACCESS after a write is pending (WaitCycles=5) -> outputs 0 immediately; after release, read of that address returns RegResetVal.
